// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the bsearch_ctrl binary-search engine.
// The optional probe counter is enabled by defining BSEARCH_PROBES_EN.
package bsearch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_LBOUND = 1'b1;

    // Computed wide so that lo+hi never overflows; the caller truncates to ADDR_W.
    function automatic logic [31:0] calc_mid(input logic [31:0] lo, input logic [31:0] hi);
        return (lo + hi) >> 1;
    endfunction

endpackage

// File: rtl/bsearch_datapath.sv
// Bisection datapath: latched target/mode, lo/hi bounds, probe address,
// comparator and result registers. Sequenced by bsearch_ctrl.
module bsearch_datapath
    import bsearch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic              cmp_en,
    input  logic              mode_in,
    input  logic [DATA_W-1:0] target_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              found,
    output logic [ADDR_W-1:0] result_idx,
    output logic              last_cmp
);

    localparam int              LH_W     = ADDR_W + 1;
    localparam logic [LH_W-1:0] DEPTH_M1 = LH_W'((1 << ADDR_W) - 1);

    logic [DATA_W-1:0] target_q, target_d;
    logic              mode_q, mode_d;
    logic [LH_W-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic [LH_W-1:0]   mid_ext, lo_n, hi_n;
    logic              is_eq, is_lt, hit, empty;
    logic [ADDR_W-1:0] next_mid, clamp_idx;

    always_comb begin
        mid_ext = {1'b0, addr_q};
        is_eq   = (mem_rdata == target_q);
        is_lt   = (mem_rdata < target_q);
        hit     = (mode_q == MODE_EXACT) && is_eq;
        lo_n    = lo_q;
        hi_n    = hi_q;
        if (is_lt)
            lo_n = mid_ext + LH_W'(1);
        else if (!hit)
            hi_n = mid_ext - LH_W'(1);
        // hi wrapping to all-ones means mid was 0: the range is empty.
        empty     = (hi_n == '1) || (lo_n > hi_n);
        last_cmp  = hit || empty;
        next_mid  = ADDR_W'(calc_mid(32'(lo_n), 32'(hi_n)));
        clamp_idx = lo_n[ADDR_W] ? DEPTH_M1[ADDR_W-1:0] : lo_n[ADDR_W-1:0];
    end

    always_comb begin
        target_d = target_q;
        mode_d   = mode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        found_d  = found_q;
        idx_d    = idx_q;
        if (launch) begin
            target_d = target_in;
            mode_d   = mode_in;
            lo_d     = '0;
            hi_d     = DEPTH_M1;
            addr_d   = ADDR_W'(calc_mid(32'd0, 32'(DEPTH_M1)));
            found_d  = 1'b0;
        end else if (cmp_en) begin
            lo_d = lo_n;
            hi_d = hi_n;
            if (hit) begin
                idx_d   = addr_q;
                found_d = 1'b1;
            end else if (empty) begin
                idx_d   = clamp_idx;
                found_d = (mode_q == MODE_LBOUND) && !lo_n[ADDR_W];
            end else begin
                addr_d = next_mid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            mode_q   <= MODE_EXACT;
            lo_q     <= '0;
            hi_q     <= '0;
            addr_q   <= '0;
            found_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            target_q <= target_d;
            mode_q   <= mode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            found_q  <= found_d;
            idx_q    <= idx_d;
        end
    end

    assign mem_addr   = addr_q;
    assign found      = found_q;
    assign result_idx = idx_q;

endmodule

// File: rtl/bsearch_ctrl.sv
// Binary-search engine top: FSM and RAM-latency wait counter around bsearch_datapath.
// Define BSEARCH_PROBES_EN to add the probes port counting CMP cycles per search.
module bsearch_ctrl
    import bsearch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] target,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] result_idx
`ifdef BSEARCH_PROBES_EN
    ,
    output logic [$clog2(ADDR_W+2)-1:0] probes
`endif
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wait_last, launch, cmp_en, last_cmp;

    assign wait_last = (wait_q == WAIT_W'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            IDLE:  if (start) state_d = PROBE;
            PROBE: begin
                if (wait_last) state_d = CMP;
                else           wait_d  = wait_q + WAIT_W'(1);
            end
            CMP:   state_d = last_cmp ? DONE : PROBE;
            DONE:  if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        launch = (state_q == IDLE) && start;
        cmp_en = (state_q == CMP);
        busy   = (state_q == PROBE) || (state_q == CMP);
        done   = (state_q == DONE);
    end

`ifdef BSEARCH_PROBES_EN
    logic [$clog2(ADDR_W+2)-1:0] probes_q, probes_d;

    always_comb begin
        probes_d = probes_q;
        if (launch)      probes_d = '0;
        else if (cmp_en) probes_d = probes_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) probes_q <= '0;
        else        probes_q <= probes_d;
    end

    assign probes = probes_q;
`endif

    bsearch_datapath #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dp (
        .clk        (clk),
        .rst_n      (reset),
        .launch     (launch),
        .cmp_en     (cmp_en),
        .mode_in    (mode),
        .target_in  (target),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .found      (found),
        .result_idx (result_idx),
        .last_cmp   (last_cmp)
    );

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Scoreboard bench for bsearch_ctrl over a RAM holding mem[i] = 2i+1.
module tb_bsearch_ctrl;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 5;
    localparam int MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [DATA_W-1:0] target = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy, done, found;
    logic [ADDR_W-1:0] result_idx;
`ifdef BSEARCH_PROBES_EN
    logic [2:0]        probes;
`endif

    bsearch_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .target     (target),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .result_idx (result_idx)
`ifdef BSEARCH_PROBES_EN
        ,
        .probes     (probes)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = DATA_W'(2 * i + 1);
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   t0;
        int   lat;
        logic fnd;
        int   idx;
        int   prb;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int addr_trace[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic m, input int t, input logic fnd, input int idx,
                         input int prb, input int lat);
        @(negedge clk);
        mode   = m;
        target = DATA_W'(t);
        start  = 1'b1;
        sbq.push_back('{cyc, lat, fnd, idx, prb});
    endtask

    task automatic wait_done();
        int k = 0;
        addr_trace.delete();
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (busy && (addr_trace.size() == 0 || addr_trace[$] != int'(mem_addr)))
                addr_trace.push_back(int'(mem_addr));
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 0);
    endtask

    // Monitor: pops one expectation per rising edge of done.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", cyc - e.t0, e.lat);
                    chk("found", found, e.fnd);
                    chk("result_idx", result_idx, e.idx);
`ifdef BSEARCH_PROBES_EN
                    chk("probes", probes, e.prb);
`endif
                end
            end
            prev = done;
        end
    end

    initial begin
        int exp63[6];
        exp63 = '{15, 23, 27, 29, 30, 31};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_result_idx", result_idx, 0);
`ifdef BSEARCH_PROBES_EN
        chk("rst_probes", probes, 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        issue(1'b0, 31, 1'b1, 15, 1, 3);
        wait_done(); release_start();

        issue(1'b0, 63, 1'b1, 31, 6, 13);
        wait_done();
        chk("trace63_len", addr_trace.size(), 6);
        for (int i = 0; i < 6 && i < addr_trace.size(); i++)
            chk("trace63_addr", addr_trace[i], exp63[i]);
        release_start();

        issue(1'b0, 32, 1'b0, 16, 5, 11); wait_done(); release_start();
        issue(1'b1, 32, 1'b1, 16, 5, 11); wait_done(); release_start();
        issue(1'b1, 0,  1'b1, 0,  5, 11); wait_done(); release_start();
        issue(1'b1, 1,  1'b1, 0,  5, 11); wait_done(); release_start();
        issue(1'b1, 64, 1'b0, 31, 6, 13); wait_done(); release_start();

        // Abort a search during its third PROBE with an async reset.
        @(negedge clk);
        mode = 1'b0; target = 8'd63; start = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_addr", mem_addr, 27);
        reset = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_found", found, 0);
        chk("async_mem_addr", mem_addr, 0);
        @(negedge clk);
        target = 8'd31;
        reset  = 1'b1;
        sbq.push_back('{cyc, 3, 1'b1, 15, 1});
        @(posedge clk); #1;
        chk("relaunch_busy", busy, 1);
        chk("relaunch_addr", mem_addr, 15);
        wait_done();

        // Start held high: DONE must hold with no relaunch.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_done_busy", {30'd0, done, busy}, 2);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold_done_drop", done, 0);
        chk("hold_found", found, 1);
        chk("hold_result_idx", result_idx, 15);

        issue(1'b0, 3, 1'b1, 1, 4, 9); wait_done(); release_start();

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
